wb_burst_mem_slave: RTL

- Synthesizable Wishbone B3 registered-feedback memory slave.
- Sits directly downstream of the BFM transactor/master pair and consumes its classic, constant and incrementing (linear/wrap4/8/16) bursts.
- Provides byte-enabled storage, programmable wait states, error response on out-of-range and address-mismatch accesses.
- Used as the reference target for randomised write-then-read checking.

---
 rtl/wb_burst_mem_slave_pkg.sv | 20 ++
 rtl/wb_burst_adr_gen.sv | 30 +++
 rtl/wb_burst_mem_slave.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_burst_mem_slave_pkg.sv
// Wishbone B3 cycle-type / burst-type codes shared by the burst memory
// slave, its address generator and any checker that decodes cti/bte.
package wb_burst_mem_slave_pkg;

  localparam logic [2:0] CLASSIC_CYCLE  = 3'b000;
  localparam logic [2:0] CONSTANT_BURST = 3'b001;
  localparam logic [2:0] INCR_BURST     = 3'b010;
  localparam logic [2:0] END_OF_BURST   = 3'b111;

  localparam logic [1:0] LINEAR_BURST  = 2'b00;
  localparam logic [1:0] WRAP_4_BURST  = 2'b01;
  localparam logic [1:0] WRAP_8_BURST  = 2'b10;
  localparam logic [1:0] WRAP_16_BURST = 2'b11;

  // Reserved cti codes fall back to classic handling.
  function automatic logic is_burst(input logic [2:0] cti);
    return (cti == CONSTANT_BURST) || (cti == INCR_BURST);
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Combinational next-word generator for Wishbone registered-feedback bursts.
// Ports: idx (current word index), cti, bte in; nxt (next word index) out.
module wb_burst_adr_gen
  import wb_burst_mem_slave_pkg::*;
#(
  parameter int aw = 32
) (
  input  logic [aw-1:0] idx,
  input  logic [2:0]    cti,
  input  logic [1:0]    bte,
  output logic [aw-1:0] nxt
);

  logic [aw-1:0] inc;

  // Wrap bursts only touch the low index bits of an aligned block.
  always_comb begin
    inc = idx + aw'(1);
    nxt = idx;
    if (cti == INCR_BURST) begin
      case (bte)
        LINEAR_BURST: nxt = inc;
        WRAP_4_BURST: nxt = {idx[aw-1:2], inc[1:0]};
        WRAP_8_BURST: nxt = {idx[aw-1:3], inc[2:0]};
        default:      nxt = {idx[aw-1:4], inc[3:0]};
      endcase
    end
  end

endmodule

// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 registered-feedback memory slave with byte enables, wait
// states, classic/constant/incrementing bursts and err on bad accesses.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; wb_adr_i, wb_dat_i,
// wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i from master;
// wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o back to master.
module wb_burst_mem_slave
  import wb_burst_mem_slave_pkg::*;
#(
  parameter int          aw          = 32,
  parameter int          dw          = 32,
  parameter int          DEPTH       = 256,
  parameter int unsigned MEM_LOW     = 0,
  parameter int          WAIT_STATES = 0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int NB = dw / 8;
  localparam int SH = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CLASSIC_ACK,
    ST_BURST,
    ST_DONE
  } state_t;

  logic [dw-1:0] mem [DEPTH];

  state_t        state;
  logic [aw-1:0] cnt;
  logic [aw-1:0] nxt;
  logic [aw-1:0] adr_idx;
  logic [3:0]    wcnt;
  logic          active;
  logic          oor;
  logic          mism;
  logic          bad;
  logic          fire;
  logic          wr;

  wb_burst_adr_gen #(.aw(aw)) u_adr_gen (
    .idx(cnt),
    .cti(wb_cti_i),
    .bte(wb_bte_i),
    .nxt(nxt)
  );

  assign adr_idx = (wb_adr_i - aw'(MEM_LOW)) >> SH;

  // Addresses below MEM_LOW wrap to huge indices and land here too.
  assign oor  = cnt >= aw'(DEPTH);
  assign mism = (state == ST_BURST) && (adr_idx != cnt);
  assign bad  = oor || mism;

  // active is the registered ack phase; the beat's own address decides
  // whether it terminates with ack or err.
  assign fire     = active && wb_cyc_i && wb_stb_i;
  assign wb_ack_o = fire && !bad;
  assign wb_err_o = fire && bad;
  assign wb_rty_o = 1'b0;
  assign wr       = wb_ack_o && wb_we_i && !wb_rst_i;

  function automatic logic [dw-1:0] rd(input logic [aw-1:0] i);
    return (i < aw'(DEPTH)) ? mem[i[IW-1:0]] : '0;
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (wr) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_sel_i[b]) begin
          mem[cnt[IW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      active   <= 1'b0;
      wcnt     <= '0;
      cnt      <= '0;
      wb_dat_o <= '0;
    end else if (!wb_cyc_i) begin
      state  <= ST_IDLE;
      active <= 1'b0;
      wcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb_stb_i) begin
            cnt  <= adr_idx;
            wcnt <= '0;
            if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
            end else begin
              active   <= 1'b1;
              wb_dat_o <= rd(adr_idx);
              state    <= is_burst(wb_cti_i) ? ST_BURST
                                             : ST_CLASSIC_ACK;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt == 4'(WAIT_STATES - 1)) begin
            active   <= 1'b1;
            wb_dat_o <= rd(cnt);
            state    <= is_burst(wb_cti_i) ? ST_BURST
                                           : ST_CLASSIC_ACK;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        ST_CLASSIC_ACK: begin
          active <= 1'b0;
          state  <= ST_DONE;
        end
        ST_BURST: begin
          if (wb_stb_i) begin
            if (bad || wb_cti_i == END_OF_BURST) begin
              active <= 1'b0;
              state  <= ST_DONE;
            end else begin
              // Preload next beat so the burst runs one beat per clock.
              cnt      <= nxt;
              wb_dat_o <= rd(nxt);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          active <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
